// File: rtl/bcd_converter.sv
// Sequential 32-bit binary to 10-digit BCD converter (double-dabble, one bit per clock).
// Define BCD_CONVERTER_BLANK_EN to output leading zero digits as 4'hF (blank).
module bcd_converter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd,
  output logic [3:0]  ndigits
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] scratch_q, scratch_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [39:0] bcd_q, bcd_d;
  logic [3:0]  ndigits_q, ndigits_d;
  logic [39:0] adj_s;
  logic [3:0]  nsig_s;

  // Add 3 to every nibble that is 5 or more, all judged on the pre-shift value.
  function automatic logic [39:0] add3_all(input logic [39:0] s);
    logic [39:0] r;
    r = s;
    for (int i = 0; i < 10; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] sig_digits(input logic [39:0] s);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (s[4*i +: 4] != 4'd0) begin
        n = 4'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  function automatic logic [39:0] format_digits(input logic [39:0] s, input logic [3:0] n);
    logic [39:0] r;
    r = s;
`ifdef BCD_CONVERTER_BLANK_EN
    for (int i = 1; i < 10; i++) begin
      if (4'(i) >= n) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
`else
    if (n == 4'd0) begin
      r = 40'h0;
    end else begin
      r = s;
    end
`endif
    return r;
  endfunction

  assign adj_s  = add3_all(scratch_q);
  assign nsig_s = sig_digits(scratch_q);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ndigits_d = ndigits_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = value;
          scratch_d = 40'h0;
          cnt_d     = 5'd0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        {scratch_d, bin_d} = {adj_s, bin_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FINISH;
        end else begin
          state_d = SHIFT;
        end
      end
      FINISH: begin
        bcd_d     = format_digits(scratch_q, nsig_s);
        ndigits_d = nsig_s;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= 32'h0;
      scratch_q <= 40'h0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= 40'h0;
      ndigits_q <= 4'd1;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ndigits_q <= ndigits_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign ndigits = ndigits_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: decimal reference model, directed cases then random traffic.
module tb_bcd_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'h0;
  logic        busy, done;
  logic [39:0] bcd;
  logic [3:0]  ndigits;

  bcd_converter dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .ndigits(ndigits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  nd;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          free_edge = 0;
  int          cur_due = 0;
  bit          active = 1'b0;
  bit          accepted = 1'b0;
  bit          mon_en = 1'b0;
  logic [39:0] last_bcd = 40'h0;
  logic [3:0]  last_nd = 4'd1;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by repeated division, no knowledge of the shift algorithm.
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    longint      x;
    int          n;
    x = v;
    e.bcd = 40'h0;
    for (int i = 0; i < 10; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    n = 1;
    x = v;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    e.nd = 4'(n);
`ifdef BCD_CONVERTER_BLANK_EN
    for (int i = 1; i < 10; i++) if (i >= n) e.bcd[4*i +: 4] = 4'hF;
`endif
    e.due = 0;
    return e;
  endfunction

  task automatic step(input logic s, input logic [31:0] v, input logic r);
    int   e;
    exp_t x;
    @(negedge clk);
    start = s;
    value = v;
    reset = r;
    e = cyc + 1;
    accepted = 1'b0;
    if (r) begin
      sb_q.delete();
      active = 1'b0;
      last_bcd = 40'h0;
      last_nd = 4'd1;
      free_edge = e + 1;
    end else if (s && e >= free_edge) begin
      x = model(v);
      x.due = e + 33;
      sb_q.push_back(x);
      active = 1'b1;
      cur_due = e + 33;
      free_edge = e + 34;
      accepted = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic run_accept(input logic [31:0] v);
    int tries = 0;
    do begin
      step(1'b1, v, 1'b0);
      tries++;
    end while (!accepted && tries < 40);
    if (!accepted) begin
      errors++;
      $display("FAIL accept_timeout value=%0d never accepted", v);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard after every edge.
  initial begin
    exp_t x;
    bit   busy_exp;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !reset) begin
        busy_exp = active && (cyc < cur_due);
        checks++;
        if (busy !== busy_exp) begin
          errors++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, busy_exp);
        end
        if (done === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d bcd=%h", cyc, bcd);
          end else begin
            x = sb_q.pop_front();
            if (bcd !== x.bcd || ndigits !== x.nd || cyc != x.due) begin
              errors++;
              $display("FAIL result cyc=%0d bcd=%h nd=%0d exp_cyc=%0d bcd=%h nd=%0d",
                       cyc, bcd, ndigits, x.due, x.bcd, x.nd);
            end
            last_bcd = x.bcd;
            last_nd = x.nd;
          end
        end else begin
          checks++;
          if (done !== 1'b0 || bcd !== last_bcd || ndigits !== last_nd) begin
            errors++;
            $display("FAIL hold cyc=%0d done=%b bcd=%h nd=%0d exp bcd=%h nd=%0d",
                     cyc, done, bcd, ndigits, last_bcd, last_nd);
          end
          if (sb_q.size() != 0 && cyc >= sb_q[0].due) begin
            checks++;
            errors++;
            $display("FAIL missing_done cyc=%0d exp_cyc=%0d", cyc, sb_q[0].due);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 32'h0, 1'b0);

    run_accept(32'd0);          idle(36);
    run_accept(32'd1234567890); idle(36);
    run_accept(32'hFFFF_FFFF);  idle(36);
    run_accept(32'd42);         idle(36);

    // Start pulses while busy must be ignored.
    run_accept(32'd99);
    for (int k = 1; k <= 40; k++) step(k == 5 || k == 20, 32'd7, 1'b0);

    // Start held high: back-to-back conversions.
    run_accept(32'd9);
    for (int k = 1; k <= 34; k++) step(1'b1, 32'd10, 1'b0);
    idle(36);

    // Reset in the middle of a conversion.
    run_accept(32'd555);
    idle(9);
    step(1'b0, 32'h0, 1'b1);
    idle(3);
    run_accept(32'd555);        idle(36);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(3, 0))
        0: v = $urandom;
        1: v = $urandom_range(999, 0);
        2: v = $urandom_range(9, 0);
        default: v = 32'd1 << $urandom_range(31, 0);
      endcase
      step($urandom_range(2, 0) == 0, v, $urandom_range(400, 0) == 0);
    end
    step(1'b0, 32'h0, 1'b0);
    idle(40);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter that consumes the 32-bit quotient produced by the repeated-subtraction divider and turns it into ten decimal digits for the display path. It uses the shift-and-add-3 (double-dabble) method, one bit per clock, behind a start/busy/done handshake. Its outputs feed the seven-segment digit multiplexer directly.

## Interface
- No parameters; widths are fixed at 32-bit binary in and 10 BCD digits out.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge at which it is sampled high.
- start  in  1  request a conversion; sampled only in IDLE.
- value  in  32  unsigned binary operand; captured on the edge that accepts start.
- busy  out  1  high from the accept edge until done rises.
- done  out  1  single-cycle pulse; bcd and ndigits are valid from this cycle.
- bcd  out  40  ten BCD nibbles; [39:36] is the most significant digit, [3:0] the least.
- ndigits  out  4  count of significant digits, 1..10; value 0 gives 1.

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE: when start=1, capture value into the 32-bit shift register and clear the 40-bit BCD scratch register and the 5-bit bit counter. Set busy=1 and go to SHIFT.
- SHIFT, each cycle, in this order:
  - For every nibble of the scratch register (all 10, evaluated in parallel on the pre-shift value), add 3 if the nibble is >= 5.
  - Shift {scratch, binary} left by 1 as a 72-bit quantity.
  - Increment the counter.
  - After the 32nd shift (counter was 31), go to FINISH.
- FINISH:
  - Register scratch into bcd.
  - Compute ndigits as 10 minus the number of leading zero nibbles, with a minimum of 1.
  - Set done=1 and busy=0, then return to IDLE.
- All corrections fit within their nibble. After a correction a nibble is at most 12, and its top bit shifts into the next nibble. No nibble ever exceeds 9 after a shift.
- bcd and ndigits hold their last values until the next FINISH. They do not change during a later conversion.
- start while busy=1 is ignored and is not queued.
- start held high continuously: a new conversion is accepted on the edge after the done cycle (back-to-back operation).
- value changing after the accept edge has no effect.
- Reset mid-conversion aborts the conversion. No done is produced, and all outputs take their reset values.

## Timing
- Reset values: busy=0, done=0, bcd=40'h0, ndigits=4'd1, state IDLE, internal registers zero.
- start is sampled high at edge N.
  - busy=1 after edge N.
  - Shifts occur at edges N+1..N+32.
  - FINISH occurs at edge N+33: done=1 and valid bcd/ndigits are visible after N+33, and busy falls at the same edge.
  - done falls at edge N+34.
- Latency from accepting start to done is 33 cycles, and is independent of value.
- The earliest next accept is edge N+34; the block's throughput is one conversion per 34 cycles.

## Configuration
- Macro: BCD_CONVERTER_BLANK_EN.
- When defined, FINISH replaces every leading zero nibble above the least significant digit with 4'hF, which the display decoder treats as blank. Digit [3:0] is never blanked.
- When undefined, leading zeros are output as 4'h0.
- ndigits is identical in both builds.

## Test plan
- Reset, then start with value=0 → done at accept+33; bcd=40'h0 (blank build: 40'hFF_FFFF_FFF0); ndigits=1.
- value=1234567890 → bcd=40'h12_3456_7890, ndigits=10, busy high for exactly 33 cycles.
- value=32'hFFFF_FFFF → bcd=40'h42_9496_7295, ndigits=10; then value=42 → bcd=40'h00_0000_0042 (blank build 40'hFF_FFFF_FF42), ndigits=2.
- start=1 for value=99, then start pulses with value=7 at accept+5 and accept+20 → both ignored; done once with bcd=40'h..99 and ndigits=2; no second done.
- start held high with value=9 then 10 → two done pulses exactly 34 cycles apart, giving ndigits 1 then 2.
- reset asserted at accept+10 of value=555 → busy=0, done never pulses, bcd=0, ndigits=1; a fresh start with value=555 then completes normally with bcd=40'h..555.
